// File: rtl/splash_sequencer.sv
// Power-on splash sequencer: forced splash hold, then armed until a fresh start press, then run.
// Define SPLASH_BLINK_EN to blink the splash frame while armed.
module splash_sequencer #(
   parameter int ROWS        = 16,
   parameter int COLS        = 16,
   parameter int SYNC_DEPTH  = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int BLINK_HALF  = 4,
   parameter logic [ROWS-1:0][COLS-1:0] SPLASH = '0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       start_btn,
   output logic [ROWS-1:0][COLS-1:0]  PixSPL,
   output logic                       STARTen,
   output logic                       busy
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   // Reject parameter values outside their legal ranges at elaboration.
   if (SYNC_DEPTH < 2 || SYNC_DEPTH > 4) begin : g_bad_sync
      $error("SYNC_DEPTH must be 2..4");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("HOLD_CYCLES must be at least 1");
   end
   if (BLINK_HALF < 1) begin : g_bad_blink
      $error("BLINK_HALF must be at least 1");
   end

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t                     r_state;
   logic [HW-1:0]              r_hold_cnt;
   logic [SYNC_DEPTH-1:0]      r_sync;
   logic                       r_edge;
   logic [ROWS-1:0][COLS-1:0]  r_pix;
   logic                       r_starten;
   logic                       r_busy;
   logic                       w_rise;
   logic [ROWS-1:0][COLS-1:0]  w_armed_pix;

`ifdef SPLASH_BLINK_EN
   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [BW-1:0]              r_blink_cnt;
   logic                       r_phase;
   logic                       w_blink_wrap;
   logic                       w_phase_nxt;

   assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
   assign w_phase_nxt  = r_phase ^ w_blink_wrap;
   // Output register is loaded with the phase that will be current after this edge.
   assign w_armed_pix  = w_phase_nxt ? '0 : SPLASH;
`else
   assign w_armed_pix  = SPLASH;
`endif

   // While HOLD is active the edge flop is pinned high, so a press already in flight
   // when ARMED is entered reads as "held" and needs a release before it can count.
   assign w_rise = r_sync[SYNC_DEPTH-1] & ~r_edge;

   // Start-button synchroniser and edge-detect flop.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync <= '0;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], start_btn};
         r_edge <= (r_state == S_HOLD) ? 1'b1 : r_sync[SYNC_DEPTH-1];
      end
   end

   // Sequencer FSM with registered frame, enable and busy outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_HOLD;
         r_hold_cnt <= '0;
         r_pix      <= SPLASH;
         r_starten  <= 1'b0;
         r_busy     <= 1'b1;
`ifdef SPLASH_BLINK_EN
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_HOLD: begin
               r_hold_cnt <= r_hold_cnt + HW'(1);
               r_pix      <= SPLASH;
               r_starten  <= 1'b0;
               r_busy     <= 1'b1;
`ifdef SPLASH_BLINK_EN
               r_blink_cnt <= '0;
               r_phase     <= 1'b0;
`endif
               if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= S_ARMED;
               end else begin
                  r_state <= S_HOLD;
               end
            end
            S_ARMED: begin
               if (w_rise) begin
                  r_state   <= S_RUN;
                  r_pix     <= '0;
                  r_starten <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_state   <= S_ARMED;
                  r_pix     <= w_armed_pix;
                  r_starten <= 1'b0;
                  r_busy    <= 1'b1;
`ifdef SPLASH_BLINK_EN
                  r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
                  r_phase     <= w_phase_nxt;
`endif
               end
            end
            S_RUN: begin
               r_state   <= S_RUN;
               r_pix     <= '0;
               r_starten <= 1'b1;
               r_busy    <= 1'b0;
            end
            default: begin
               r_state   <= S_HOLD;
               r_pix     <= SPLASH;
               r_starten <= 1'b0;
               r_busy    <= 1'b1;
            end
         endcase
      end
   end

   assign PixSPL  = r_pix;
   assign STARTen = r_starten;
   assign busy    = r_busy;

endmodule

// File: tb/tb_splash_sequencer.sv
// Self-checking bench for splash_sequencer: fixed vector table, hand sequences, and
// randomized traffic against a timeline-based reference model.
module tb_splash_sequencer;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int SD   = 2;
   localparam int HOLD = 3;
   localparam int BH   = 2;
   localparam logic [15:0] SPL = 16'hA5C3;
`ifdef SPLASH_BLINK_EN
   localparam logic [15:0] BLK_OFF = 16'h0000;
   localparam bit BLINK = 1'b1;
`else
   localparam logic [15:0] BLK_OFF = SPL;
   localparam bit BLINK = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic start_btn = 1'b0;
   logic [ROWS-1:0][COLS-1:0] PixSPL;
   logic STARTen;
   logic busy;

   int checks = 0;
   int errors = 0;

   // Reference model: per-posedge button samples and the edge at which ARMED begins.
   int t = 0;
   int armed_at = 32'h4000_0000;
   bit run = 1'b0;
   bit hist [0:4095];
   bit exp_start;
   logic [15:0] exp_pix;

   typedef struct {
      bit rst;
      bit btn;
      bit e_start;
      bit e_busy;
      logic [15:0] e_pix;
   } vec_t;
   vec_t tbl [23];

   always #5 CLK = ~CLK;

   splash_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .SYNC_DEPTH(SD), .HOLD_CYCLES(HOLD),
      .BLINK_HALF(BH), .SPLASH(SPL)
   ) dut (
      .CLK(CLK), .RST(RST), .start_btn(start_btn),
      .PixSPL(PixSPL), .STARTen(STARTen), .busy(busy)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, t, act, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the posedge, settle outputs.
   task automatic step(input bit rst, input bit btn);
      RST = rst;
      start_btn = btn;
      @(posedge CLK);
      if (rst) begin
         hist[t]  = 1'b0;
         armed_at = t + HOLD;
         run      = 1'b0;
      end else begin
         hist[t] = btn;
         // A press first sampled at N (N in ARMED, previous sample low) starts the game at N+SD.
         if (!run && (t - SD) >= armed_at && hist[t-SD] && !hist[t-SD-1])
            run = 1'b1;
      end
      exp_start = run;
      if (run)
         exp_pix = 16'h0000;
      else if (t < armed_at)
         exp_pix = SPL;
      else if (BLINK && (((t - armed_at) / BH) % 2) == 1)
         exp_pix = 16'h0000;
      else
         exp_pix = SPL;
      #1;
      t++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_start"}, {15'd0, STARTen}, {15'd0, exp_start});
      chk({tag, "_busy"},  {15'd0, busy},    {15'd0, ~exp_start});
      chk({tag, "_pix"},   PixSPL,           exp_pix);
   endtask

   initial begin
      bit rb;
      bit bb;

      // Reset hold, normal start, terminal RUN, mid-game reset, button pulse in HOLD.
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, SPL};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, SPL};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, BLK_OFF};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, BLK_OFF};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, SPL};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, SPL};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, SPL};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, BLK_OFF};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, BLK_OFF};
      tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, SPL};

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].rst, tbl[i].btn);
         chk($sformatf("tbl%0d_start", i), {15'd0, STARTen}, {15'd0, tbl[i].e_start});
         chk($sformatf("tbl%0d_busy", i),  {15'd0, busy},    {15'd0, tbl[i].e_busy});
         chk($sformatf("tbl%0d_pix", i),   PixSPL,           tbl[i].e_pix);
      end

      // Button held through reset and HOLD never starts; release then re-press does.
      step(1'b1, 1'b1);
      check_model("held_rst");
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b1);
         chk("held_start", {15'd0, STARTen}, 16'd0);
         chk("held_busy",  {15'd0, busy},    16'd1);
      end
      step(1'b0, 1'b0);
      chk("release_start", {15'd0, STARTen}, 16'd0);
      step(1'b0, 1'b1);
      chk("repress_n", {15'd0, STARTen}, 16'd0);
      step(1'b0, 1'b1);
      chk("repress_n1", {15'd0, STARTen}, 16'd0);
      step(1'b0, 1'b1);
      chk("repress_n2_start", {15'd0, STARTen}, 16'd1);
      chk("repress_n2_busy",  {15'd0, busy},    16'd0);
      chk("repress_n2_pix",   PixSPL,           16'h0000);

      // Reset wins over a rise that would otherwise start the game on the same edge.
      step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check_model("prio_pre");
      step(1'b1, 1'b1);
      chk("prio_start", {15'd0, STARTen}, 16'd0);
      chk("prio_pix",   PixSPL,           SPL);
      step(1'b0, 1'b1);
      check_model("prio_post");

      // Randomized traffic with occasional resets.
      bb = 1'b0;
      for (int i = 0; i < 800; i++) begin
         rb = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) bb = ~bb;
         step(rb, bb);
         check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
